// File: rtl/operand_buf_pkg.sv
// Shared widths and flattened-bus slice helpers for the operand buffer and its slots.
package operand_buf_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_TAG_WIDTH     = 6;
  localparam int DEF_PAYLOAD_WIDTH = 48;

  // Low bit index of element idx in a flattened bus of width-bit elements.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/operand_slot.sv
// One stored operand: holds value or rename tag and captures a matching CDB broadcast,
// lowest port first; an operand being loaded is matched against the same-cycle broadcast.
module operand_slot
  import operand_buf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
  parameter int CDB_PORTS  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load,
  input  logic                            load_is_ref,
  input  logic [DATA_WIDTH-1:0]           load_data,
  input  logic [CDB_PORTS-1:0]            cdb_valid,
  input  logic [CDB_PORTS*TAG_WIDTH-1:0]  cdb_tag,
  input  logic [CDB_PORTS*DATA_WIDTH-1:0] cdb_data,
  output logic                            is_ref,
  output logic [DATA_WIDTH-1:0]           data
);

  logic                  cand_ref;
  logic [DATA_WIDTH-1:0] cand_data;
  logic                  next_ref;
  logic [DATA_WIDTH-1:0] next_data;

  // Walk ports from highest to lowest so the lowest matching index is applied last and wins.
  always_comb begin
    cand_ref  = load ? load_is_ref : is_ref;
    cand_data = load ? load_data : data;
    next_ref  = cand_ref;
    next_data = cand_data;
    for (int p = CDB_PORTS - 1; p >= 0; p--) begin
      if (cand_ref && cdb_valid[p] &&
          (cdb_tag[slice_lo(p, TAG_WIDTH) +: TAG_WIDTH] == cand_data[TAG_WIDTH-1:0])) begin
        next_ref  = 1'b0;
        next_data = cdb_data[slice_lo(p, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      is_ref <= 1'b0;
      data   <= '0;
    end else begin
      is_ref <= next_ref;
      data   <= next_data;
    end
  end

endmodule

// File: rtl/operand_buf.sv
// In-order operand buffer: entries wait until every operand is resolved from the CDB,
// then leave from the head; full/empty come from the occupancy count.
module operand_buf
  import operand_buf_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int TAG_WIDTH     = DEF_TAG_WIDTH,
  parameter int NUM_SRC       = 2,
  parameter int CDB_PORTS     = 2,
  parameter int DEPTH         = 4,
  parameter int PAYLOAD_WIDTH = DEF_PAYLOAD_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_SRC-1:0]              in_is_ref,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   in_data,
  input  logic [PAYLOAD_WIDTH-1:0]        in_payload,
  input  logic [CDB_PORTS-1:0]            cdb_valid,
  input  logic [CDB_PORTS*TAG_WIDTH-1:0]  cdb_tag,
  input  logic [CDB_PORTS*DATA_WIDTH-1:0] cdb_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_SRC*DATA_WIDTH-1:0]   out_data,
  output logic [PAYLOAD_WIDTH-1:0]        out_payload,
  output logic [$clog2(DEPTH):0]          count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0]                wr_ptr;
  logic [PTR_W-1:0]                rd_ptr;
  logic [CNT_W-1:0]                cnt;
  logic [DEPTH-1:0][NUM_SRC-1:0]   slot_ref;
  logic [DATA_WIDTH-1:0]           slot_data [DEPTH][NUM_SRC];
  logic [PAYLOAD_WIDTH-1:0]        payload_q [DEPTH];
  logic                            enq;
  logic                            deq;

  assign in_ready  = (cnt != FULL);
  assign out_valid = (cnt != '0) && !(|slot_ref[rd_ptr]);
  // flush wins over both transfers in its cycle.
  assign enq       = in_valid && in_ready && !flush;
  assign deq       = out_valid && out_ready && !flush;
  assign count     = cnt;

  for (genvar d = 0; d < DEPTH; d++) begin : g_entry
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      operand_slot #(
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH),
        .CDB_PORTS  (CDB_PORTS)
      ) u_slot (
        .clk         (clk),
        .rst         (rst),
        .load        (enq && (wr_ptr == PTR_W'(d))),
        .load_is_ref (in_is_ref[s]),
        .load_data   (in_data[slice_lo(s, DATA_WIDTH) +: DATA_WIDTH]),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .is_ref      (slot_ref[d][s]),
        .data        (slot_data[d][s])
      );
    end
  end

  always_comb begin
    out_data = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      out_data[slice_lo(s, DATA_WIDTH) +: DATA_WIDTH] = slot_data[rd_ptr][s];
    end
    out_payload = payload_q[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int d = 0; d < DEPTH; d++) begin
        payload_q[d] <= '0;
      end
    end else if (enq) begin
      payload_q[wr_ptr] <= in_payload;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_buf.sv
// Directed bench for operand_buf: stimulus pushes expected head entries into a scoreboard,
// a negedge monitor pops and compares on every out_valid&&out_ready handshake.
module tb_operand_buf;

  localparam int DW = 32;
  localparam int TW = 6;
  localparam int PW = 48;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_is_ref = '0;
  logic [2*DW-1:0] in_data = '0;
  logic [PW-1:0] in_payload = '0;
  logic [1:0]    cdb_valid = '0;
  logic [2*TW-1:0] cdb_tag = '0;
  logic [2*DW-1:0] cdb_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2*DW-1:0] out_data;
  logic [PW-1:0] out_payload;
  logic [2:0]    count;

  typedef struct {
    logic [2*DW-1:0] data;
    logic [PW-1:0]   payload;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  operand_buf #(
    .DATA_WIDTH(DW), .TAG_WIDTH(TW), .NUM_SRC(2), .CDB_PORTS(2), .DEPTH(4), .PAYLOAD_WIDTH(PW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_ref(in_is_ref), .in_data(in_data), .in_payload(in_payload),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_payload(out_payload), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [2*DW-1:0] act, input logic [2*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [DW-1:0] op0, input logic [DW-1:0] op1, input logic [PW-1:0] pl);
    exp_t e;
    e.data = {op1, op0};
    e.payload = pl;
    sb.push_back(e);
  endtask

  // Offer one entry for exactly one clock; returns #1 after the edge.
  task automatic enq(input logic r0, input logic [DW-1:0] d0, input logic r1,
                     input logic [DW-1:0] d1, input logic [PW-1:0] pl);
    in_is_ref  = {r1, r0};
    in_data    = {d1, d0};
    in_payload = pl;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cdb(input logic [1:0] v, input logic [TW-1:0] t0, input logic [DW-1:0] d0,
                         input logic [TW-1:0] t1, input logic [DW-1:0] d1);
    cdb_valid = v;
    cdb_tag   = {t1, t0};
    cdb_data  = {d1, d0};
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got data %h with empty scoreboard", out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_payload", {16'h0, out_payload}, {16'h0, e.payload});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    idle(2);
    chk("reset_count", {61'h0, count}, 64'd0);
    chk("reset_in_ready", {63'h0, in_ready}, 64'd1);
    chk("reset_out_valid", {63'h0, out_valid}, 64'd0);
    chk("reset_out_data", out_data, 64'd0);
    rst = 1'b1;
    idle(1);

    // Two plain entries stream straight through
    out_ready = 1'b1;
    push_exp(32'd1, 32'd2, 48'h100);
    enq(1'b0, 32'd1, 1'b0, 32'd2, 48'h100);
    chk("plain_valid_next", {63'h0, out_valid}, 64'd1);
    push_exp(32'd3, 32'd4, 48'h101);
    enq(1'b0, 32'd3, 1'b0, 32'd4, 48'h101);
    idle(2);
    chk("plain_count_zero", {61'h0, count}, 64'd0);

    // Ref operand resolved by CDB port 1 two cycles after enqueue
    push_exp(32'hDEAD, 32'd7, 48'h200);
    enq(1'b1, 32'd5, 1'b0, 32'd7, 48'h200);
    chk("ref_wait_valid", {63'h0, out_valid}, 64'd0);
    idle(1);
    chk("ref_still_wait", {63'h0, out_valid}, 64'd0);
    set_cdb(2'b10, 6'd0, 32'd0, 6'd5, 32'hDEAD);
    idle(1);
    set_cdb(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
    chk("ref_valid_after_cdb", {63'h0, out_valid}, 64'd1);
    idle(2);

    // Both ports hit the same tag: port 0 wins
    push_exp(32'hA, 32'h11, 48'h300);
    enq(1'b1, 32'd7, 1'b0, 32'h11, 48'h300);
    set_cdb(2'b11, 6'd7, 32'hA, 6'd7, 32'hB);
    idle(1);
    set_cdb(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
    idle(2);

    // A non-ref operand whose low bits equal a broadcast tag stays untouched
    push_exp(32'h45, 32'h77, 48'h400);
    enq(1'b0, 32'h45, 1'b1, 32'd5, 48'h400);
    set_cdb(2'b01, 6'd5, 32'h77, 6'd0, 32'd0);
    idle(1);
    set_cdb(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
    idle(2);

    // Same-cycle CDB hit on an incoming ref operand
    push_exp(32'h55, 32'h22, 48'h500);
    set_cdb(2'b01, 6'd3, 32'h55, 6'd0, 32'd0);
    enq(1'b1, 32'd3, 1'b0, 32'h22, 48'h500);
    set_cdb(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
    chk("bypass_valid_next", {63'h0, out_valid}, 64'd1);
    idle(2);

    // Fill, reject overflow, then simultaneous enq/deq across pointer wrap
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_exp(32'h600 + i, 32'h700 + i, 48'h600 + i);
      enq(1'b0, 32'h600 + i, 1'b0, 32'h700 + i, 48'h600 + i);
    end
    chk("full_count", {61'h0, count}, 64'd4);
    chk("full_in_ready", {63'h0, in_ready}, 64'd0);
    enq(1'b0, 32'hBAD, 1'b0, 32'hBAD, 48'hBAD);
    chk("full_ignored_count", {61'h0, count}, 64'd4);
    out_ready = 1'b1;
    idle(1);
    chk("after_deq_count", {61'h0, count}, 64'd3);
    for (int i = 0; i < 5; i++) begin
      push_exp(32'h800 + i, 32'h900 + i, 48'h800 + i);
      enq(1'b0, 32'h800 + i, 1'b0, 32'h900 + i, 48'h800 + i);
      chk("wrap_count", {61'h0, count}, 64'd3);
    end
    idle(4);
    chk("drain_count", {61'h0, count}, 64'd0);

    // Flush with a concurrent enqueue drops everything
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      enq(1'b0, 32'hA00 + i, 1'b0, 32'hB00 + i, 48'hA00 + i);
    end
    chk("pre_flush_count", {61'h0, count}, 64'd3);
    flush = 1'b1;
    enq(1'b0, 32'hCCC, 1'b0, 32'hDDD, 48'hCCC);
    flush = 1'b0;
    chk("flush_count", {61'h0, count}, 64'd0);
    chk("flush_out_valid", {63'h0, out_valid}, 64'd0);

    // Reset mid-stream dominates enqueue and CDB activity
    enq(1'b0, 32'hE01, 1'b0, 32'hE02, 48'hE00);
    enq(1'b1, 32'd9, 1'b0, 32'hE03, 48'hE01);
    rst = 1'b0;
    set_cdb(2'b01, 6'd9, 32'h99, 6'd0, 32'd0);
    enq(1'b0, 32'hF01, 1'b0, 32'hF02, 48'hF00);
    set_cdb(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
    chk("midrst_count", {61'h0, count}, 64'd0);
    chk("midrst_in_ready", {63'h0, in_ready}, 64'd1);
    chk("midrst_out_valid", {63'h0, out_valid}, 64'd0);
    chk("midrst_out_data", out_data, 64'd0);
    rst = 1'b1;
    idle(2);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
